adc_ctrl_regs: RTL
==================

# adc_ctrl_regs

Parametrised AXI4-Lite control block for the ADC front end. It extends the single-config-register design to `NUM_CFG` writable config words, `NUM_STATUS` read-only status words and a buffered AXIS command path: a `FIFO_DEPTH`-entry queue with level, overflow and flush control, replacing the single-word AXIS register. It sits between the PS AXI4-Lite interconnect and the ADC core's command/config inputs.

## Interface
- `NUM_CFG`, 2, number of 32-bit config registers (1..12)
- `NUM_STATUS`, 2, number of 32-bit status inputs (1..16)
- `FIFO_DEPTH`, 8, AXIS command FIFO depth (power of two, 2..256)
- `CFG_RESET`, 32'h0, reset value of every config register
- `aclk`  in  1  sole clock; all logic on rising edge
- `aresetn`  in  1  reset, synchronous, active-low
- `cfg`  out  32*NUM_CFG  config register i at bits [32i+31:32i]
- `status`  in  32*NUM_STATUS  status word j at bits [32j+31:32j], sampled on read
- `m_axis_tdata`  out  32  FIFO head word
- `m_axis_tvalid`  out  1  FIFO not empty
- `m_axis_tready`  in  1  ADC core accepts head
- `s_axi_lite_aw*`, `s_axi_lite_w*`, `s_axi_lite_b*`, `s_axi_lite_ar*`, `s_axi_lite_r*`: standard AXI4-Lite subordinate, 32-bit address/data, 4-bit wstrb, 3-bit prot (ignored)

## Operation
- Address decode uses word index addr[11:2]; addr[1:0] and upper bits are ignored
- 0x000 VERSION, RO: 32'hADC1_0000 | NUM_CFG<<8 | NUM_STATUS
- 0x004 FIFO_STAT, RO: [15:0] level, [16] full, [17] empty, [18] overflow (sticky)
- 0x008 FIFO_CTRL, WO, self-clearing: bit0=1 flushes the FIFO, bit1=1 clears overflow
- 0x00C AXIS_DATA, WO: push wdata into the FIFO; wstrb must be 4'hF, otherwise SLVERR and no push
- 0x010+4i CFG[i], RW, byte-enabled by wstrb
- 0x040+4j STATUS[j], RO
- Any other address, writes to RO registers, reads of WO registers, and indices at or above NUM_CFG/NUM_STATUS: SLVERR (2'b10), no side effect, rdata 0
- Write FSM: W_IDLE (awready=wready=1) → W_HAVE_A (aw captured, awready=0) or W_HAVE_W (w captured, wready=0) → commit when both are held → W_RESP (bvalid=1, bresp set) → W_IDLE on bready. AW and W arriving in the same cycle go directly to commit.
- Read FSM: R_IDLE (arready=1) → on ar handshake, register rdata/rresp → R_DATA (rvalid=1, held stable) → R_IDLE on rready
- AXIS_DATA push while full, with no pop in the same cycle: word dropped, overflow set, bresp SLVERR
- Push and pop in the same cycle: allowed at any level, including full; level unchanged
- Flush and pop in the same cycle: flush wins, level=0; flush and push in the same cycle: flush, then the push word becomes the sole entry

## Timing
- Reset (aresetn low at an edge): cfg=CFG_RESET, FIFO empty, overflow=0, awready/wready/arready/bvalid/rvalid=0, bresp/rresp=0, m_axis_tvalid=0. Ready signals go high on the first edge after release.
- Reset mid-transaction aborts it; no response is issued and FIFO contents are lost
- Write commit edge: cfg, the FIFO push and FIFO_CTRL take effect at the commit edge; bvalid rises at the same edge
- Minimum write: 2 cycles AW/W→B; back-to-back writes accepted every 2 cycles with bready held high
- Read latency: rvalid 1 cycle after the ar handshake; status is sampled at the handshake edge
- FIFO: first-word fall-through; a pushed word appears on m_axis_tdata with tvalid=1 on the cycle after the commit edge; tdata is stable while tvalid && !tready
- Level counter width: $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH

## Configuration
- `ADC_CTRL_IRQ_EN` defined: adds output `irq` (1 bit), registered, high while overflow=1 or (FIFO empty and previous cycle non-empty, one-cycle pulse); reset 0
- Not defined: no `irq` port; the overflow flag remains readable in FIFO_STAT

## Test plan
- Reset, then read 0x000 with defaults → rdata 32'hADC1_0202, rresp 0; read 0x010 → 0
- Write 0x014 = 32'hA5A5_1234 with wstrb 4'b0011, then read 0x014 → 32'h0000_1234; `cfg[63:32]` matches from the commit edge on
- AW issued 3 cycles before W to 0x010 → a single B response with OKAY, and the write lands only when W arrives
- With tready=0, push 9 words 1..9 (depth 8) → the 9th write gets SLVERR, FIFO_STAT = 0x0005_0008; raise tready → words 1..8 out in order, then empty
- Write 0x008 = 3 with 4 entries queued → level 0, overflow 0, tvalid low the next cycle
- Read 0x0C0 and write 0x004 → SLVERR each; registers and FIFO unchanged

Source files
------------

// File: rtl/adc_ctrl_regs.sv
// AXI4-Lite control block for the ADC front end: config/status words plus a buffered AXIS command FIFO.
// Optional overflow/drain interrupt output is enabled by defining ADC_CTRL_IRQ_EN.

module adc_ctrl_regs #(
    parameter int          NUM_CFG    = 2,
    parameter int          NUM_STATUS = 2,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] CFG_RESET  = 32'h0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    output logic [32*NUM_CFG-1:0]     cfg,
    input  logic [32*NUM_STATUS-1:0]  status,
    output logic [31:0]               m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    input  logic [31:0]               s_axi_lite_awaddr,
    input  logic [2:0]                s_axi_lite_awprot,
    input  logic                      s_axi_lite_awvalid,
    output logic                      s_axi_lite_awready,
    input  logic [31:0]               s_axi_lite_wdata,
    input  logic [3:0]                s_axi_lite_wstrb,
    input  logic                      s_axi_lite_wvalid,
    output logic                      s_axi_lite_wready,
    output logic [1:0]                s_axi_lite_bresp,
    output logic                      s_axi_lite_bvalid,
    input  logic                      s_axi_lite_bready,
    input  logic [31:0]               s_axi_lite_araddr,
    input  logic [2:0]                s_axi_lite_arprot,
    input  logic                      s_axi_lite_arvalid,
    output logic                      s_axi_lite_arready,
    output logic [31:0]               s_axi_lite_rdata,
    output logic [1:0]                s_axi_lite_rresp,
    output logic                      s_axi_lite_rvalid,
    input  logic                      s_axi_lite_rready
`ifdef ADC_CTRL_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          LW      = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [31:0] VERSION = 32'hADC1_0000 | (32'(NUM_CFG) << 8) | 32'(NUM_STATUS);
    localparam logic [1:0]  W_IDLE = 2'd0, W_HAVE_A = 2'd1, W_HAVE_W = 2'd2, W_RESP = 2'd3;
    localparam logic [0:0]  R_IDLE = 1'b0, R_DATA = 1'b1;
    localparam logic [1:0]  RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;

    logic [1:0]    w_state_q, w_state_d;
    logic [0:0]    r_state_q;
    logic [9:0]    aw_idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [31:0]   rdata_q;
    logic [31:0]   cfg_q [NUM_CFG];
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;

    logic          aw_hs_s, w_hs_s, commit_s;
    logic [9:0]    c_idx_s;
    logic [31:0]   c_data_s;
    logic [3:0]    c_strb_s;
    logic          cfg_wr_s, ctrl_wr_s, push_req_s, push_s, pop_s, flush_s, clr_ovf_s, ovf_set_s, wr_ok_s;
    logic          full_s, empty_s;
    logic [9:0]    ar_idx_s;
    logic [31:0]   rd_data_s;
    logic          rd_err_s;
    logic          unused_s;

    assign unused_s = ^{s_axi_lite_awaddr[31:12], s_axi_lite_awaddr[1:0], s_axi_lite_awprot,
                        s_axi_lite_araddr[31:12], s_axi_lite_araddr[1:0], s_axi_lite_arprot};

    assign aw_hs_s  = s_axi_lite_awvalid && awready_q;
    assign w_hs_s   = s_axi_lite_wvalid && wready_q;
    assign full_s   = (level_q == DEPTH_L);
    assign empty_s  = (level_q == {LW{1'b0}});
    assign pop_s    = !empty_s && m_axis_tready;
    assign ar_idx_s = s_axi_lite_araddr[11:2];

    // Write FSM next state; the commit operands come from whichever channel is live on the bus.
    always_comb begin
        w_state_d = w_state_q;
        commit_s  = 1'b0;
        c_idx_s   = aw_idx_q;
        c_data_s  = wdata_q;
        c_strb_s  = wstrb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    commit_s  = 1'b1;
                    c_idx_s   = s_axi_lite_awaddr[11:2];
                    c_data_s  = s_axi_lite_wdata;
                    c_strb_s  = s_axi_lite_wstrb;
                    w_state_d = W_RESP;
                end else if (aw_hs_s) begin
                    w_state_d = W_HAVE_A;
                end else if (w_hs_s) begin
                    w_state_d = W_HAVE_W;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_HAVE_A: begin
                if (w_hs_s) begin
                    commit_s  = 1'b1;
                    c_data_s  = s_axi_lite_wdata;
                    c_strb_s  = s_axi_lite_wstrb;
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_HAVE_A;
                end
            end
            W_HAVE_W: begin
                if (aw_hs_s) begin
                    commit_s  = 1'b1;
                    c_idx_s   = s_axi_lite_awaddr[11:2];
                    w_state_d = W_RESP;
                end else begin
                    w_state_d = W_HAVE_W;
                end
            end
            W_RESP: begin
                if (s_axi_lite_bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write decode and FIFO next state; a full FIFO still accepts a push when the head pops this cycle.
    always_comb begin
        cfg_wr_s   = commit_s && (c_idx_s >= 10'd4) && (c_idx_s < 10'(4 + NUM_CFG));
        ctrl_wr_s  = commit_s && (c_idx_s == 10'd2);
        push_req_s = commit_s && (c_idx_s == 10'd3) && (c_strb_s == 4'hF);
        flush_s    = ctrl_wr_s && c_data_s[0];
        clr_ovf_s  = ctrl_wr_s && c_data_s[1];
        push_s     = push_req_s && (!full_s || pop_s || flush_s);
        ovf_set_s  = push_req_s && !push_s;
        wr_ok_s    = cfg_wr_s || ctrl_wr_s || push_s;

        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        level_d = level_q;
        if (flush_s) begin
            rptr_d  = wptr_q;
            level_d = {LW{1'b0}};
        end else if (push_s && !pop_s) begin
            level_d = level_q + LW'(1);
        end else if (pop_s && !push_s) begin
            level_d = level_q - LW'(1);
        end else begin
            level_d = level_q;
        end
        if (pop_s && !flush_s) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_d;
        end
        if (push_s) begin
            wptr_d = wptr_q + AW'(1);
            if (flush_s) begin
                level_d = LW'(1);
            end else begin
                level_d = level_d;
            end
        end else begin
            wptr_d = wptr_q;
        end

        if (clr_ovf_s) begin
            ovf_d = 1'b0;
        end else if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Read decode; write-only and unmapped words return SLVERR with zero data.
    always_comb begin
        rd_data_s = 32'h0;
        rd_err_s  = 1'b1;
        if (ar_idx_s == 10'd0) begin
            rd_data_s = VERSION;
            rd_err_s  = 1'b0;
        end else if (ar_idx_s == 10'd1) begin
            rd_data_s = {13'd0, ovf_q, empty_s, full_s, {(16-LW){1'b0}}, level_q};
            rd_err_s  = 1'b0;
        end else begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (ar_idx_s == 10'(4 + i)) begin
                    rd_data_s = cfg_q[i];
                    rd_err_s  = 1'b0;
                end
            end
            for (int j = 0; j < NUM_STATUS; j++) begin
                if (ar_idx_s == 10'(16 + j)) begin
                    rd_data_s = status[32*j +: 32];
                    rd_err_s  = 1'b0;
                end
            end
        end
    end

    // FIFO storage carries no reset; the pointers define which entries are live.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_q[wptr_q] <= c_data_s;
        end
    end

    // Control state, handshakes, config words and FIFO bookkeeping.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_idx_q  <= 10'd0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= 32'h0;
            wptr_q    <= {AW{1'b0}};
            rptr_q    <= {AW{1'b0}};
            level_q   <= {LW{1'b0}};
            ovf_q     <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) begin
                cfg_q[i] <= CFG_RESET;
            end
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
            wready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
            bvalid_q  <= (w_state_d == W_RESP);
            if (aw_hs_s) begin
                aw_idx_q <= s_axi_lite_awaddr[11:2];
            end
            if (w_hs_s) begin
                wdata_q <= s_axi_lite_wdata;
                wstrb_q <= s_axi_lite_wstrb;
            end
            if (commit_s) begin
                bresp_q <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
            for (int i = 0; i < NUM_CFG; i++) begin
                if (cfg_wr_s && (c_idx_s == 10'(4 + i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (c_strb_s[b]) begin
                            cfg_q[i][8*b +: 8] <= c_data_s[8*b +: 8];
                        end
                    end
                end
            end
            case (r_state_q)
                R_IDLE: begin
                    if (s_axi_lite_arvalid && arready_q) begin
                        rdata_q   <= rd_data_s;
                        rresp_q   <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_lite_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef ADC_CTRL_IRQ_EN
    logic irq_q;

    // Interrupt follows the sticky overflow and pulses once when the queue drains.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ovf_d || ((level_d == {LW{1'b0}}) && !empty_s);
        end
    end

    assign irq = irq_q;
`endif

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg
        assign cfg[32*g +: 32] = cfg_q[g];
    end

    assign m_axis_tdata       = mem_q[rptr_q];
    assign m_axis_tvalid      = !empty_s;
    assign s_axi_lite_awready = awready_q;
    assign s_axi_lite_wready  = wready_q;
    assign s_axi_lite_bvalid  = bvalid_q;
    assign s_axi_lite_bresp   = bresp_q;
    assign s_axi_lite_arready = arready_q;
    assign s_axi_lite_rvalid  = rvalid_q;
    assign s_axi_lite_rresp   = rresp_q;
    assign s_axi_lite_rdata   = rdata_q;

endmodule
